// File: rtl/alignment_shifter_pkg.sv
// Shared FPU package for the alignment shifter.
// Contents: align_state_t (FSM encoding), default datapath width and the
// localparams derived from it, and a helper that sizes the stage counter.
package fpu_pkg;

  typedef enum logic [1:0] {
    ALIGN_IDLE,
    ALIGN_SHIFT,
    ALIGN_DONE
  } align_state_t;

  localparam int ALIGN_INPUT_WIDTH  = 64;
  localparam int ALIGN_SHIFT_WIDTH  = $clog2(ALIGN_INPUT_WIDTH);
  localparam int ALIGN_AMOUNT_WIDTH = ALIGN_SHIFT_WIDTH + 1;

  // Bits needed to count 0..shift_width-1 (at least one bit).
  function automatic int align_stage_bits(input int shift_width);
    return (shift_width > 1) ? $clog2(shift_width) : 1;
  endfunction

endpackage

// File: rtl/alignment_shifter_if.sv
// Request/response bundle for the alignment shifter.
// Request side : input_valid, input_ready, input_vector, shift_amount
// Response side: output_valid, output_ready, output_vector, sticky_bit
// master = producer/consumer around the block, slave = the shifter itself.
interface alignment_shifter_if import fpu_pkg::*; #(
  parameter int INPUT_WIDTH = ALIGN_INPUT_WIDTH
) ();
  localparam int SHIFT_WIDTH = $clog2(INPUT_WIDTH);

  logic                   input_valid;
  logic                   input_ready;
  logic [INPUT_WIDTH-1:0] input_vector;
  logic [SHIFT_WIDTH:0]   shift_amount;
  logic                   output_valid;
  logic                   output_ready;
  logic [INPUT_WIDTH-1:0] output_vector;
  logic                   sticky_bit;

  modport master (
    output input_valid, input_vector, shift_amount, output_ready,
    input  input_ready, output_valid, output_vector, sticky_bit
  );

  modport slave (
    input  input_valid, input_vector, shift_amount, output_ready,
    output input_ready, output_valid, output_vector, sticky_bit
  );
endinterface

// File: rtl/alignment_shift_stage.sv
// One power-of-two right-shift stage (combinational).
// Ports: data (in), stage index (in, distance = 2**stage), enable (in),
//        shifted (out), sticky (out: OR of bits dropped by this stage).
// Macro ALIGNMENT_SHIFTER_STICKY_EN: when undefined sticky is tied to 0.
module alignment_shift_stage import fpu_pkg::*; #(
  parameter  int INPUT_WIDTH = ALIGN_INPUT_WIDTH,
  localparam int SHIFT_WIDTH = $clog2(INPUT_WIDTH),
  localparam int STAGE_BITS  = align_stage_bits(SHIFT_WIDTH)
) (
  input  logic [INPUT_WIDTH-1:0] data,
  input  logic [STAGE_BITS-1:0]  stage,
  input  logic                   enable,
  output logic [INPUT_WIDTH-1:0] shifted,
  output logic                   sticky
);

  // Largest stage distance is INPUT_WIDTH/2, which fits in SHIFT_WIDTH bits.
  logic [SHIFT_WIDTH-1:0] distance;
  assign distance = SHIFT_WIDTH'(1) << stage;

  assign shifted = enable ? (data >> distance) : data;

`ifdef ALIGNMENT_SHIFTER_STICKY_EN
  logic [INPUT_WIDTH-1:0] low_mask;
  // Mask of the bits that fall off the bottom at this distance.
  assign low_mask = ~({INPUT_WIDTH{1'b1}} << distance);
  assign sticky   = enable & (|(data & low_mask));
`else
  assign sticky = 1'b0;
`endif

endmodule

// File: rtl/alignment_shifter.sv
// Iterative logical right shifter with sticky bit for FPU operand alignment.
// One power-of-two stage per cycle; amounts >= INPUT_WIDTH finish in one edge.
// Ports: clock, reset (sync, active-high), bus (alignment_shifter_if.slave).
// Macro ALIGNMENT_SHIFTER_STICKY_EN: enables sticky computation; otherwise
// sticky_bit is driven 0 and shift timing is unchanged.
module alignment_shifter import fpu_pkg::*; #(
  parameter int INPUT_WIDTH = ALIGN_INPUT_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  alignment_shifter_if.slave  bus
);

  localparam int SHIFT_WIDTH = $clog2(INPUT_WIDTH);
  localparam int STAGE_BITS  = align_stage_bits(SHIFT_WIDTH);
  localparam logic [STAGE_BITS-1:0] LAST_STAGE = STAGE_BITS'(SHIFT_WIDTH - 1);

  align_state_t           state, state_n;
  logic [INPUT_WIDTH-1:0] data_q;
  logic [SHIFT_WIDTH-1:0] amount_q;
  logic [STAGE_BITS-1:0]  stage_q;
  logic [INPUT_WIDTH-1:0] result_q;

  logic [INPUT_WIDTH-1:0] stage_data;
  logic                   stage_sticky;
  logic                   accept, saturate, last_stage;

  assign accept     = bus.input_valid && (state == ALIGN_IDLE);
  // Amounts are at most 2*INPUT_WIDTH-1, so the top bit alone flags >= INPUT_WIDTH.
  assign saturate   = bus.shift_amount[SHIFT_WIDTH];
  assign last_stage = (stage_q == LAST_STAGE);

  alignment_shift_stage #(.INPUT_WIDTH(INPUT_WIDTH)) u_stage (
    .data    (data_q),
    .stage   (stage_q),
    .enable  (amount_q[stage_q]),
    .shifted (stage_data),
    .sticky  (stage_sticky)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ALIGN_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ALIGN_IDLE:  if (accept) state_n = saturate ? ALIGN_DONE : ALIGN_SHIFT;
      ALIGN_SHIFT: if (last_stage) state_n = ALIGN_DONE;
      ALIGN_DONE:  if (bus.output_ready) state_n = ALIGN_IDLE;
      default:     state_n = ALIGN_IDLE;
    endcase
  end

  // result_q is separate from data_q so the visible output holds the last
  // result while a new request is being shifted.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q   <= '0;
      amount_q <= '0;
      stage_q  <= '0;
      result_q <= '0;
    end else begin
      case (state)
        ALIGN_IDLE: if (accept) begin
          stage_q <= '0;
          if (saturate) begin
            result_q <= '0;
          end else begin
            data_q   <= bus.input_vector;
            amount_q <= bus.shift_amount[SHIFT_WIDTH-1:0];
          end
        end
        ALIGN_SHIFT: begin
          data_q  <= stage_data;
          stage_q <= stage_q + 1'b1;
          if (last_stage) result_q <= stage_data;
        end
        default: ;
      endcase
    end
  end

`ifdef ALIGNMENT_SHIFTER_STICKY_EN
  logic sticky_q, result_sticky_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_q        <= 1'b0;
      result_sticky_q <= 1'b0;
    end else begin
      case (state)
        ALIGN_IDLE: if (accept) begin
          sticky_q <= 1'b0;
          if (saturate) result_sticky_q <= |bus.input_vector;
        end
        ALIGN_SHIFT: begin
          sticky_q <= sticky_q | stage_sticky;
          if (last_stage) result_sticky_q <= sticky_q | stage_sticky;
        end
        default: ;
      endcase
    end
  end

  assign bus.sticky_bit = result_sticky_q;
`else
  logic unused_stage_sticky;
  assign unused_stage_sticky = stage_sticky;
  assign bus.sticky_bit      = 1'b0;
`endif

  assign bus.input_ready   = (state == ALIGN_IDLE);
  assign bus.output_valid  = (state == ALIGN_DONE);
  assign bus.output_vector = result_q;

endmodule

// File: tb/tb_alignment_shifter.sv
// Scoreboard bench for alignment_shifter (INPUT_WIDTH = 64).
// The driver pushes the expected result of each accepted request; an
// independent negedge monitor pops and compares on every output handshake.
module tb_alignment_shifter;
  import fpu_pkg::*;

  localparam int W   = 64;
  localparam int LAT = $clog2(W) + 1;

  typedef struct {
    logic [W-1:0] vec;
    logic         sticky;
    int           lat;
    int           acc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alignment_shifter_if #(.INPUT_WIDTH(W)) bus ();

  alignment_shifter #(.INPUT_WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   stall_rdy = 1'b0;
  bit   rand_rdy  = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    bus.output_ready = stall_rdy ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: logical right shift, sticky = any 1 among the discarded bits.
  function automatic exp_t model(input logic [W-1:0] v, input int a);
    exp_t e;
    if (a >= W) begin
      e.vec    = '0;
      e.sticky = (v != '0);
      e.lat    = 1;
    end else begin
      e.vec    = v >> a;
      e.sticky = ((v & ((64'd1 << a) - 64'd1)) != '0);
      e.lat    = LAT;
    end
`ifndef ALIGNMENT_SHIFTER_STICKY_EN
    e.sticky = 1'b0;
`endif
    e.acc = 0;
    return e;
  endfunction

  // ---------------- monitor ----------------
  bit           prev_v = 1'b0;
  int           first_cyc = 0;
  logic [W-1:0] hold_vec;
  logic         hold_st;

  always @(negedge clock) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (bus.output_valid) begin
        if (!prev_v) begin
          first_cyc = cyc;
          hold_vec  = bus.output_vector;
          hold_st   = bus.sticky_bit;
        end else begin
          check("hold_vector", bus.output_vector, hold_vec);
          check("hold_sticky", 64'(bus.sticky_bit), 64'(hold_st));
        end
        if (bus.output_ready) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("vector", bus.output_vector, e.vec);
            check("sticky", 64'(bus.sticky_bit), 64'(e.sticky));
            check("latency_edges", 64'(first_cyc - e.acc + 1), 64'(e.lat));
          end
        end
      end
      prev_v = bus.output_valid && !bus.output_ready;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [W-1:0] v, input int a);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clock);
    bus.input_valid  = 1'b1;
    bus.input_vector = v;
    bus.shift_amount = 7'(a);
    while (!bus.input_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!bus.input_ready) begin
      fail_now("accept_timeout");
      bus.input_valid = 1'b0;
      return;
    end
    e     = model(v, a);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    bus.input_valid  = 1'b0;
    bus.input_vector = {$urandom, $urandom};
    bus.shift_amount = 7'($urandom_range(0, 127));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
    @(negedge clock);
  endtask

  initial begin
    int   n;
    bit   seen;
    exp_t e;

    bus.input_valid  = 1'b0;
    bus.input_vector = '0;
    bus.shift_amount = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_output_valid", 64'(bus.output_valid), 64'd0);
    check("reset_output_vector", bus.output_vector, 64'd0);
    check("reset_sticky", 64'(bus.sticky_bit), 64'd0);
    check("reset_input_ready", 64'(bus.input_ready), 64'd1);
    reset = 1'b0;

    // Directed corners
    send(64'h8000_0000_0000_0000, 63);
    send(64'h0000_0000_0000_00FF, 4);
    send(64'h1, 64);
    send(64'hA5, 0);
    send(64'h0, 127);
    send(64'hFFFF_FFFF_FFFF_FFFF, 127);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1);
    wait_drain();

    // Backpressure: result held, new request ignored until the handshake.
    stall_rdy = 1'b1;
    @(negedge clock);
    @(negedge clock);
    send(64'hDEAD_BEEF_0123_4567, 13);
    n = 0;
    while (!bus.output_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!bus.output_valid) fail_now("stall_valid_timeout");
    bus.input_valid  = 1'b1;
    bus.input_vector = 64'h1234_5678_9ABC_DEF0;
    bus.shift_amount = 7'd8;
    repeat (10) begin
      @(negedge clock);
      check("stall_input_ready", 64'(bus.input_ready), 64'd0);
      check("stall_output_valid", 64'(bus.output_valid), 64'd1);
    end
    stall_rdy = 1'b0;
    @(posedge clock);
    @(negedge clock);
    e     = model(64'h1234_5678_9ABC_DEF0, 8);
    e.acc = cyc + 2;
    sb.push_back(e);
    @(negedge clock);
    check("release_input_ready", 64'(bus.input_ready), 64'd1);
    check("release_output_valid", 64'(bus.output_valid), 64'd0);
    @(negedge clock);
    check("next_accept_input_ready", 64'(bus.input_ready), 64'd0);
    bus.input_valid = 1'b0;
    wait_drain();

    // Reset while in SHIFT stage 3: no output must ever appear.
    bus.input_valid  = 1'b1;
    bus.input_vector = 64'hF0F0_F0F0_F0F0_F0F1;
    bus.shift_amount = 7'd21;
    check("midreset_idle_ready", 64'(bus.input_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
    bus.input_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("midreset_input_ready", 64'(bus.input_ready), 64'd1);
    check("midreset_output_valid", 64'(bus.output_valid), 64'd0);
    check("midreset_output_vector", bus.output_vector, 64'd0);
    check("midreset_sticky", 64'(bus.sticky_bit), 64'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (bus.output_valid) seen = 1'b1;
    end
    check("midreset_no_valid_pulse", 64'(seen), 64'd0);

    // Randomized traffic with random output backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      int a;
      case ($urandom_range(0, 5))
        0:       a = 0;
        1:       a = W - 1;
        2:       a = W;
        default: a = $urandom_range(0, 2 * W - 1);
      endcase
      send({$urandom, $urandom} >> $urandom_range(0, 40), a);
    end
    wait_drain();
    rand_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
